// File: rtl/t05_find_least_if.sv
// ---------------------------------------------------------------------------
// t05_find_least_if -- histogram SRAM read bus used by t05_find_least.
//   hist_addr : 8-bit read address            (master -> slave)
//   wr_r_en   : 2-bit command, 0 read, 3 idle (master -> slave)
//   sram_in   : 32-bit count returned          (slave -> master)
//   busy_i    : SRAM busy, data valid when 0   (slave -> master)
// ---------------------------------------------------------------------------
interface t05_find_least_if;
  logic [7:0]  hist_addr;
  logic [1:0]  wr_r_en;
  logic [31:0] sram_in;
  logic        busy_i;

  modport master (output hist_addr, output wr_r_en, input sram_in, input busy_i);
  modport slave  (input hist_addr, input wr_r_en, output sram_in, output busy_i);
endinterface

// File: rtl/t05_find_least.sv
// ---------------------------------------------------------------------------
// t05_find_least -- scans a 256-entry histogram held in an external SRAM and
// reports the two byte values with the smallest nonzero counts.
//   clk         : system clock, rising edge
//   nrst        : synchronous active-low reset
//   start       : level request to begin a scan (acted on in IDLE only)
//   bus         : SRAM read bus (hist_addr, wr_r_en, sram_in, busy_i)
//   least1_idx/least1_cnt : smallest nonzero count and its byte value
//   least2_idx/least2_cnt : second-smallest nonzero count and its byte value
//   done        : one-cycle pulse when the results are updated
//   no_pair     : valid with done, fewer than two nonzero entries seen
// Each entry costs REQ + at least two WAIT cycles + CMP. Ties keep the
// lower address because every comparison is strict.
// ---------------------------------------------------------------------------
module t05_find_least #(
  parameter int NUM_ENTRIES = 256
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  t05_find_least_if.master        bus,
  output logic [7:0]              least1_idx,
  output logic [7:0]              least2_idx,
  output logic [31:0]             least1_cnt,
  output logic [31:0]             least2_cnt,
  output logic                    done,
  output logic                    no_pair
);

  localparam logic [7:0]  LAST_ADDR = 8'(NUM_ENTRIES - 1);
  localparam logic [31:0] CNT_EMPTY = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CMP, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_addr;
  logic        r_first_wait;
  logic [31:0] r_data;
  logic [31:0] r_cnt1, r_cnt2;
  logic [7:0]  r_idx1, r_idx2;
  logic        r_v1, r_v2;
  logic [7:0]  r_least1_idx, r_least2_idx;
  logic [31:0] r_least1_cnt, r_least2_cnt;
  logic        r_done, r_no_pair;

  logic [31:0] w_cnt1_nxt, w_cnt2_nxt;
  logic [7:0]  w_idx1_nxt, w_idx2_nxt;
  logic        w_v1_nxt, w_v2_nxt;
  logic        w_last;

  assign w_last = (r_addr == LAST_ADDR);

  // Next-state and bus command.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt  = r_state;
    bus.wr_r_en  = 2'd3;
    case (r_state)
      IDLE: if (start) w_state_nxt = REQ;
      REQ: begin
        bus.wr_r_en = 2'd0;
        w_state_nxt = WAIT;
      end
      // The first WAIT cycle ignores busy_i: the SRAM has not yet seen the read.
      WAIT: if (!r_first_wait && !bus.busy_i) w_state_nxt = CMP;
      CMP:  w_state_nxt = w_last ? DONE : REQ;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.hist_addr = r_addr;

  // Tracker update for the captured count. An empty slot accepts any nonzero
  // count, which is how 32'hFFFF_FFFF gets kept.
  always_comb begin
    w_cnt1_nxt = r_cnt1;
    w_idx1_nxt = r_idx1;
    w_v1_nxt   = r_v1;
    w_cnt2_nxt = r_cnt2;
    w_idx2_nxt = r_idx2;
    w_v2_nxt   = r_v2;
    if (r_data != 32'd0) begin
      if (!r_v1 || r_data < r_cnt1) begin
        w_cnt2_nxt = r_cnt1;
        w_idx2_nxt = r_idx1;
        w_v2_nxt   = r_v1;
        w_cnt1_nxt = r_data;
        w_idx1_nxt = r_addr;
        w_v1_nxt   = 1'b1;
      end else if (!r_v2 || r_data < r_cnt2) begin
        w_cnt2_nxt = r_data;
        w_idx2_nxt = r_addr;
        w_v2_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop.
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_addr       <= 8'd0;
      r_first_wait <= 1'b0;
      r_data       <= 32'd0;
      r_cnt1       <= CNT_EMPTY;
      r_cnt2       <= CNT_EMPTY;
      r_idx1       <= 8'd0;
      r_idx2       <= 8'd0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_least1_idx <= 8'd0;
      r_least2_idx <= 8'd0;
      r_least1_cnt <= 32'd0;
      r_least2_cnt <= 32'd0;
      r_done       <= 1'b0;
      r_no_pair    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_addr <= 8'd0;
          r_cnt1 <= CNT_EMPTY;
          r_cnt2 <= CNT_EMPTY;
          r_idx1 <= 8'd0;
          r_idx2 <= 8'd0;
          r_v1   <= 1'b0;
          r_v2   <= 1'b0;
        end
        REQ:  r_first_wait <= 1'b1;
        WAIT: begin
          if (r_first_wait)      r_first_wait <= 1'b0;
          else if (!bus.busy_i)  r_data       <= bus.sram_in;
        end
        CMP: begin
          r_cnt1 <= w_cnt1_nxt;
          r_cnt2 <= w_cnt2_nxt;
          r_idx1 <= w_idx1_nxt;
          r_idx2 <= w_idx2_nxt;
          r_v1   <= w_v1_nxt;
          r_v2   <= w_v2_nxt;
          if (w_last) begin
            // Results are loaded on entry to DONE so they appear with done
            // and hold until the next scan completes.
            r_done       <= 1'b1;
            r_no_pair    <= !(w_v1_nxt && w_v2_nxt);
            r_least1_idx <= w_v1_nxt ? w_idx1_nxt : 8'd0;
            r_least1_cnt <= w_v1_nxt ? w_cnt1_nxt : 32'd0;
            r_least2_idx <= w_v2_nxt ? w_idx2_nxt : 8'd0;
            r_least2_cnt <= w_v2_nxt ? w_cnt2_nxt : 32'd0;
          end else begin
            r_addr <= r_addr + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign least1_idx = r_least1_idx;
  assign least2_idx = r_least2_idx;
  assign least1_cnt = r_least1_cnt;
  assign least2_cnt = r_least2_cnt;
  assign done       = r_done;
  assign no_pair    = r_no_pair;

endmodule

// File: tb/tb_t05_find_least.sv
// ---------------------------------------------------------------------------
// tb_t05_find_least -- directed bench for t05_find_least with a behavioural
// SRAM holding the histogram and a configurable busy time per read.
// ---------------------------------------------------------------------------
module tb_t05_find_least;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [7:0]  least1_idx, least2_idx;
  logic [31:0] least1_cnt, least2_cnt;
  logic        done, no_pair;

  t05_find_least_if sram_bus ();

  t05_find_least dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .bus        (sram_bus),
    .least1_idx (least1_idx),
    .least2_idx (least2_idx),
    .least1_cnt (least1_cnt),
    .least2_cnt (least2_cnt),
    .done       (done),
    .no_pair    (no_pair)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: latches the address on a read command and stays busy
  // for busy_len cycles afterwards.
  logic [31:0] hist [256];
  logic [7:0]  rd_addr = 8'd0;
  int          busy_cnt = 0;
  int          busy_len = 0;

  assign sram_bus.sram_in = hist[rd_addr];
  assign sram_bus.busy_i  = (busy_cnt != 0);

  always @(negedge clk) begin
    if (sram_bus.wr_r_en == 2'd0) begin
      rd_addr  = sram_bus.hist_addr;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
  end

  // Activity monitor, sampled 1 time unit after the rising edge.
  int         n_req = 0;
  int         n_done = 0;
  int         n_done_rst = 0;
  int         n_req_rst = 0;
  bit         got_first = 1'b0;
  logic [7:0] first_addr = 8'd0;

  always @(posedge clk) begin
    #1;
    if (!nrst) begin
      got_first  = 1'b0;
      n_done_rst = 0;
      n_req_rst  = 0;
    end else begin
      if (sram_bus.wr_r_en == 2'd0) begin
        n_req     = n_req + 1;
        n_req_rst = n_req_rst + 1;
        if (!got_first) begin
          got_first  = 1'b1;
          first_addr = sram_bus.hist_addr;
        end
      end
      if (done) begin
        n_done     = n_done + 1;
        n_done_rst = n_done_rst + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 256; i++) hist[i] = 32'd0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic check_result(input string tag,
                              input logic [7:0] e_idx1, input logic [31:0] e_cnt1,
                              input logic [7:0] e_idx2, input logic [31:0] e_cnt2,
                              input logic e_np);
    check({tag, "_idx1"}, 32'(least1_idx), 32'(e_idx1));
    check({tag, "_cnt1"}, least1_cnt, e_cnt1);
    check({tag, "_idx2"}, 32'(least2_idx), 32'(e_idx2));
    check({tag, "_cnt2"}, least2_cnt, e_cnt2);
    check({tag, "_no_pair"}, 32'(no_pair), 32'(e_np));
  endtask

  // One full scan started by a one-cycle start pulse.
  task automatic do_scan(input string tag,
                         input logic [7:0] e_idx1, input logic [31:0] e_cnt1,
                         input logic [7:0] e_idx2, input logic [31:0] e_cnt2,
                         input logic e_np);
    int base;
    base  = n_req;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
    check_result(tag, e_idx1, e_cnt1, e_idx2, e_cnt2, e_np);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    repeat (4) @(negedge clk);
    check({tag, "_req_count"}, 32'(n_req - base), 32'd256);
  endtask

  task automatic load_abc();
    clear_hist();
    hist[8'h61] = 32'd5;
    hist[8'h62] = 32'd3;
    hist[8'h63] = 32'd9;
  endtask

  initial begin
    int base_req, base_done;
    bit hit;
    nrst  = 1'b0;
    start = 1'b0;
    clear_hist();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wr_r_en",  32'(sram_bus.wr_r_en), 32'd3);
    check("rst_addr",     32'(sram_bus.hist_addr), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_no_pair",  32'(no_pair), 32'd0);
    check("rst_l1_cnt",   least1_cnt, 32'd0);
    check("rst_l2_idx",   32'(least2_idx), 32'd0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_wr", 32'(sram_bus.wr_r_en), 32'd3);

    // 'a'=5, 'b'=3, 'c'=9
    load_abc();
    do_scan("abc", 8'h62, 32'd3, 8'h61, 32'd5, 1'b0);

    // Tie: lower address wins slot 1
    clear_hist();
    hist[8'h10] = 32'd4;
    hist[8'h20] = 32'd4;
    do_scan("tie", 8'h10, 32'd4, 8'h20, 32'd4, 1'b0);

    // Single entry at the last address, then no wrap
    clear_hist();
    hist[8'hFF] = 32'd7;
    do_scan("last", 8'hFF, 32'd7, 8'h00, 32'd0, 1'b1);
    base_req = n_req;
    repeat (10) @(negedge clk);
    check("last_no_wrap", 32'(n_req - base_req), 32'd0);

    // Busy SRAM: same answer as the zero-busy run
    busy_len = 5;
    load_abc();
    do_scan("busy5", 8'h62, 32'd3, 8'h61, 32'd5, 1'b0);
    busy_len = 0;

    // Maximum counts are kept while slots are empty
    clear_hist();
    hist[8'h05] = 32'hFFFF_FFFF;
    hist[8'h09] = 32'hFFFF_FFFF;
    do_scan("max", 8'h05, 32'hFFFF_FFFF, 8'h09, 32'hFFFF_FFFF, 1'b0);

    // Slot shifting: 0x40=20, 0x80=10, 0x90=2, 0xA0=10 (tie with slot 2)
    clear_hist();
    hist[8'h40] = 32'd20;
    hist[8'h80] = 32'd10;
    hist[8'h90] = 32'd2;
    hist[8'hA0] = 32'd10;
    do_scan("shift", 8'h90, 32'd2, 8'h80, 32'd10, 1'b0);

    // All zero
    clear_hist();
    do_scan("zero", 8'h00, 32'd0, 8'h00, 32'd0, 1'b1);

    // Reset mid-scan at entry 100, then rescan
    load_abc();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (sram_bus.wr_r_en == 2'd0 && sram_bus.hist_addr == 8'd100) hit = 1'b1;
    end
    check("midrst_reached_100", 32'(hit), 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check("midrst_wr_r_en", 32'(sram_bus.wr_r_en), 32'd3);
    check("midrst_addr",    32'(sram_bus.hist_addr), 32'd0);
    check("midrst_l1_cnt",  least1_cnt, 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", 32'(n_done_rst), 32'd0);
    check("midrst_idle",    32'(n_req_rst), 32'd0);
    do_scan("rescan", 8'h62, 32'd3, 8'h61, 32'd5, 1'b0);
    check("rescan_first_addr", 32'(first_addr), 32'd0);
    check("rescan_one_done",   32'(n_done_rst), 32'd1);

    // start held high through DONE: back-to-back scans
    base_req  = n_req;
    base_done = n_done;
    start = 1'b1;
    wait_done("held1");
    check_result("held1", 8'h62, 32'd3, 8'h61, 32'd5, 1'b0);
    @(negedge clk);
    check("held_idle_wr", 32'(sram_bus.wr_r_en), 32'd3);
    check("held_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("held_restart_wr",   32'(sram_bus.wr_r_en), 32'd0);
    check("held_restart_addr", 32'(sram_bus.hist_addr), 32'd0);
    wait_done("held2");
    start = 1'b0;
    check_result("held2", 8'h62, 32'd3, 8'h61, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    check("held_done_count", 32'(n_done - base_done), 32'd2);
    check("held_req_count",  32'(n_req - base_req), 32'd512);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
